// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - serial line and received-word bundle for uart_rx_param
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_serial;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 busy;

    modport master (
        output rx_serial,
        input  data_out, valid, parity_err, frame_err, break_det, busy
    );

    modport slave (
        input  rx_serial,
        output data_out, valid, parity_err, frame_err, break_det, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with 3-sample majority voting
// Parity checking is compiled only when UART_RX_PARITY_EN is defined.
module uart_rx_param #(
    parameter int FREQ      = 24_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_param_if.slave  bus
);
    localparam int BIT_CNT = FREQ / BAUD_RATE;
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = $clog2(BIT_CNT);
    localparam int IW      = $clog2(DATA_BITS);

    localparam logic [CW-1:0] C_PRE  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_MID  = CW'(HALF);
    localparam logic [CW-1:0] C_RES  = CW'(HALF + 1);
    localparam logic [CW-1:0] C_END  = CW'(BIT_CNT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_WAIT   = 3'd6;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       PAR_ON   = (PARITY != 0);
    localparam logic       PAR_ODD  = (PARITY == 1);
`endif

    if (BIT_CNT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
        $error("uart_rx_param: unsupported parameter set");
    end

    logic [1:0]           sync_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fe_acc_q, fe_acc_d, brk_acc_q, brk_acc_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 ferr_q, ferr_d, brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
    logic                 pe_acc_q, pe_acc_d, perr_q, perr_d;
`endif

    logic rx, maj, at_res, at_end, in_bit, fe_now, brk_now;

    assign rx     = sync_q[1];
    assign maj    = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
    assign at_res = (cnt_q == C_RES);
    assign at_end = (cnt_q == C_END);
    assign in_bit = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP)
`ifdef UART_RX_PARITY_EN
                    || (state_q == S_PARITY)
`endif
                    ;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        shift_d   = shift_q;
        fe_acc_d  = fe_acc_q;
        brk_acc_d = brk_acc_q;
        dout_d    = dout_q;
        ferr_d    = ferr_q;
        brk_d     = brk_q;
        fe_now    = fe_acc_q | ~maj;
        brk_now   = brk_acc_q & ~maj;
`ifdef UART_RX_PARITY_EN
        pe_acc_d  = pe_acc_q;
        perr_d    = perr_q;
`endif
        if (in_bit) begin
            if (cnt_q == C_PRE) s0_d = rx;
            if (cnt_q == C_MID) s1_d = rx;
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d   = S_START;
                    idx_d     = '0;
                    stop_d    = 1'b0;
                    fe_acc_d  = 1'b0;
                    brk_acc_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    pe_acc_d  = 1'b0;
`endif
                end
            end
            S_START: begin
                if (at_res && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_res) begin
                    shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                    brk_acc_d = brk_now;
                end
                if (at_end) begin
                    if (idx_q == I_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PAR_ON ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (at_res) begin
                    pe_acc_d  = ((^shift_q) ^ maj) != PAR_ODD;
                    brk_acc_d = brk_now;
                end
                if (at_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (at_res) begin
                    fe_acc_d  = fe_now;
                    brk_acc_d = brk_now;
                    // Leave at the last stop sample, not the bit end, so a back-to-back start is caught.
                    if (stop_q == S_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        dout_d  = shift_q;
                        ferr_d  = fe_now;
                        brk_d   = brk_now;
`ifdef UART_RX_PARITY_EN
                        perr_d  = pe_acc_q;
`endif
                    end
                end else if (at_end) begin
                    stop_d = 1'b1;
                end
            end
            S_DONE:  state_d = ferr_q ? S_WAIT : S_IDLE;
            S_WAIT:  if (rx) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            stop_q    <= 1'b0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            shift_q   <= '0;
            fe_acc_q  <= 1'b0;
            brk_acc_q <= 1'b0;
            dout_q    <= '0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_acc_q  <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], bus.rx_serial};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stop_q    <= stop_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            shift_q   <= shift_d;
            fe_acc_q  <= fe_acc_d;
            brk_acc_q <= brk_acc_d;
            dout_q    <= dout_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
`ifdef UART_RX_PARITY_EN
            pe_acc_q  <= pe_acc_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.valid      = (state_q == S_DONE);
    assign bus.frame_err  = ferr_q;
    assign bus.break_det  = brk_q;
    assign bus.busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param at 10 clocks per bit
module tb_uart_rx_param;
    localparam int BIT = 10;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 2;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    exp_t q[$];
    exp_t e;
    logic busy_pending = 1'b0;
    logic exp_busy = 1'b0;

    uart_rx_param_if #(.DATA_BITS(8)) bus ();

    uart_rx_param #(
        .FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(PAR), .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe, input logic brk);
        exp_t r;
        r.d = d; r.pe = pe; r.fe = fe; r.brk = brk;
        return r;
    endfunction

    always @(negedge clk) begin
        if (busy_pending) begin
            chk("busy_after_valid", 32'(bus.busy), 32'(exp_busy));
            busy_pending = 1'b0;
        end
        if (!rst && bus.valid) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: got valid=1 data 0x%0h, required no frame", bus.data_out);
            end else begin
                e = q.pop_front();
                chk("data_out",   32'(bus.data_out),   32'(e.d));
                chk("parity_err", 32'(bus.parity_err), 32'(e.pe));
                chk("frame_err",  32'(bus.frame_err),  32'(e.fe));
                chk("break_det",  32'(bus.break_det),  32'(e.brk));
                busy_pending = 1'b1;
                exp_busy     = e.fe;
            end
        end
    end

    task automatic line(input logic v, input int n);
        bus.rx_serial = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [7:0] d);
        line(1'b0, BIT);
        for (int i = 0; i < 8; i++) line(d[i], BIT);
    endtask

    // Well-formed frame; the parity bit is only on the wire when the checker exists.
    task automatic good(input logic [7:0] d);
        q.push_back(mk(d, 1'b0, 1'b0, 1'b0));
        send_data(d);
`ifdef UART_RX_PARITY_EN
        line(^d, BIT);
`endif
        line(1'b1, BIT);
    endtask

    task automatic send_par(input logic [7:0] d, input logic pbit);
        send_data(d);
        line(pbit, BIT);
        line(1'b1, BIT);
    endtask

    initial begin
        logic seen;
        bus.rx_serial = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",      32'(bus.valid),      32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_data_out",   32'(bus.data_out),   32'd0);
        chk("rst_parity_err", 32'(bus.parity_err), 32'd0);
        chk("rst_frame_err",  32'(bus.frame_err),  32'd0);
        chk("rst_break_det",  32'(bus.break_det),  32'd0);
        rst = 1'b0;
        line(1'b1, 5);

        good(8'hA5);
        line(1'b1, 2 * BIT);

        // Two-cycle low glitch: START entered then abandoned.
        line(1'b0, 2);
        bus.rx_serial = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        chk("glitch_busy_seen", 32'(seen), 32'd1);
        chk("glitch_busy_end",  32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;

`ifdef UART_RX_PARITY_EN
        q.push_back(mk(8'h07, 1'b1, 1'b0, 1'b0));
        send_par(8'h07, 1'b0);
        q.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
        send_par(8'h07, 1'b1);
`else
        // Without the checker a low parity bit lands in the stop slot.
        q.push_back(mk(8'h07, 1'b0, 1'b1, 1'b0));
        send_par(8'h07, 1'b0);
        q.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
        send_par(8'h07, 1'b1);
`endif
        line(1'b1, 2 * BIT);

        q.push_back(mk(8'h3C, 1'b0, 1'b1, 1'b0));
        send_data(8'h3C);
`ifdef UART_RX_PARITY_EN
        line(^8'h3C, BIT);
`endif
        line(1'b0, BIT);
        line(1'b0, 3 * BIT);
        line(1'b1, 2 * BIT);
        good(8'h3C);
        line(1'b1, 2 * BIT);

        good(8'h81);
        good(8'h7E);
        line(1'b1, 2 * BIT);

        q.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1));
        line(1'b0, 20 * BIT);
        line(1'b1, 2 * BIT);

        // 0xF0 frame aborted by reset in data bit 4; rest of the line stays high.
        line(1'b0, BIT);
        for (int i = 0; i < 4; i++) line(1'b0, BIT);
        line(1'b1, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid",     32'(bus.valid),     32'd0);
        chk("midrst_busy",      32'(bus.busy),      32'd0);
        chk("midrst_data_out",  32'(bus.data_out),  32'd0);
        chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        chk("midrst_break_det", 32'(bus.break_det), 32'd0);
        @(posedge clk);
        #1;
        line(1'b1, 6 * BIT);
        good(8'h5A);
        line(1'b1, 2 * BIT);

        for (int i = 0; i < 1000 && q.size() != 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the successor to the fixed 8N1 receiver in the LCD-driver serial front end. It supports a configurable data width, optional parity, 1 or 2 stop bits and 3-sample majority voting. It also reports framing, parity and break conditions. It sits between the board RX pin and the command decoder that feeds the LCD controller, and delivers one byte/word per frame with a single-cycle valid strobe.

## Interface
- FREQ, 24_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in baud. BIT_CNT = FREQ/BAUD_RATE, which must be ≥ 8. HALF = BIT_CNT/2 (integer division).
- DATA_BITS, 8: payload bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Only honoured when UART_RX_PARITY_EN is defined.
- STOP_BITS, 1: 1 or 2.

- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_serial  in  1  asynchronous serial line. Idle level is high.
- data_out  out  DATA_BITS  last received payload. Held until the next valid.
- valid  out  1  one-cycle pulse when a frame completes, including frames with errors.
- parity_err  out  1  parity mismatch for the frame qualified by valid.
- frame_err  out  1  a stop bit was sampled low.
- break_det  out  1  all payload, parity and stop samples were low.
- busy  out  1  high in every state except IDLE.

## Operation
- rx_serial passes through a 2-flop synchroniser. Both flops reset to 1.
- A bit counter of width $clog2(BIT_CNT) restarts at 0 at each bit boundary.
- Within each bit, the line is sampled at counts HALF-1, HALF and HALF+1. The bit value is the majority of the 3 samples, resolved at count HALF+1.
- States: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE.
- IDLE: when the synchronised line is 0, go to START with the counter at 0.
- START: at HALF+1, if the majority is 1, treat it as a glitch and go to IDLE with no output. Otherwise count to BIT_CNT-1, then go to DATA.
- DATA: shift in DATA_BITS bits LSB-first, one per bit period. After the last bit reaches BIT_CNT-1:
  - go to PARITY if parity is active;
  - otherwise go to STOP.
- PARITY: the sampled bit is checked so that payload XOR parity bit equals 1 (odd) or 0 (even). A mismatch latches the internal error.
- STOP:
  - Each stop bit is resolved at HALF+1.
  - A low stop sample sets the internal frame error.
  - For STOP_BITS=2 the first stop bit runs to BIT_CNT-1 before the second begins.
  - After the last stop bit resolves, go straight to DONE without waiting for the bit end, to allow resynchronisation.
- DONE (1 cycle):
  - data_out, parity_err, frame_err and break_det update together with valid=1.
  - Go to WAIT_IDLE if frame_err, otherwise to IDLE.
- WAIT_IDLE: stay until the synchronised line is 1, then go to IDLE. A held-low break therefore produces exactly one valid.
- The error flags reflect only the most recent frame. They are cleared or set at each DONE, never sticky across frames.

## Timing
- Reset values:
  - data_out = 0, valid = 0, parity_err = 0, frame_err = 0, break_det = 0, busy = 0;
  - state = IDLE, synchroniser = 1, counter = 0.
- rst has priority over everything, including mid-frame reset. Any partial frame is discarded with no valid.
- Latency: valid asserts 1 cycle after the HALF+1 sample of the final stop bit. Input-to-state delay from the synchroniser is 2 cycles.
- busy rises the cycle after the start edge is seen and falls the cycle after DONE or WAIT_IDLE exits.
- There is no back-pressure. The consumer must take data_out on the valid cycle or before the next valid.
- Minimum frame-to-frame gap: 0 idle bits. A start edge during the final half stop bit is accepted, because the receiver is already in IDLE.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY parameter is honoured, the PARITY state exists and parity_err is driven.
- UART_RX_PARITY_EN undefined:
  - the PARITY state and parity logic are not compiled;
  - DATA goes directly to STOP;
  - parity_err is tied to 0;
  - a frame carrying a parity bit is decoded as no-parity (its parity bit is read as the first stop bit).

## Test plan
Bench parameters: FREQ=1_000_000, BAUD_RATE=100_000 (BIT_CNT=10, HALF=5), DATA_BITS=8, PARITY=0, STOP_BITS=1 unless stated.

- Send 0xA5 as 8N1 -> one valid pulse; data_out=0xA5; all error flags 0; busy low 1 cycle after valid.
- Drive rx low for 2 cycles, then high -> no valid; state returns to IDLE; busy pulses only during START.
- With PARITY=2 and the macro defined, send 0x07 with parity bit 0 -> valid; data_out=0x07; parity_err=1. Resending with parity bit 1 gives parity_err=0.
- Send 0x3C with a low stop bit and hold low for 3 more bit times, then high, then send 0x3C correctly:
  - first frame: valid with frame_err=1, then WAIT_IDLE;
  - second frame: valid with data_out=0x3C and frame_err=0.
- Hold rx low for 20 bit times -> exactly one valid; data_out=0x00; frame_err=1; break_det=1.
- Assert rst for 1 cycle during data bit 4 of a frame -> all outputs 0 the next cycle, no valid. A following 0x5A frame is received correctly.
